// File: rtl/vec_max_normalize.sv
// vec_max_normalize
//
// Finds the maximum element of a signed fixed-point vector and subtracts
// it from every element. The result feeds the softmax input: all elements
// become <= 0, which keeps the exponentials in range.
//
// The maximum is found by a sequential scan, one element per clock. The
// subtraction of all elements then happens in a single SUB cycle.
//
// Parameters
//   VEC_SIZE   : number of vector elements (>= 1)
//   DATA_WIDTH : signed element width
//   FIXED_PNT  : fractional bits. The arithmetic does not depend on the
//                binary point, so this parameter is only range checked.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : request. Held high until data_valid pulses. Dropping it
//                during SCAN or SUB aborts the operation.
//   vec_in     : raw scores; element i is vec_in[i]. Sampled on the
//                start edge only.
//   data_valid : one-cycle pulse marking vec_out/max_out/max_idx valid
//   vec_out    : element[i] - max, saturated to the most negative value
//   max_out    : vector maximum
//   max_idx    : lowest index holding the maximum
//   busy       : high while scanning or subtracting
module vec_max_normalize #(
  parameter int VEC_SIZE   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  localparam int IDX_W     = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  vec_in,
  output logic                                 data_valid,
  output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]  vec_out,
  output logic [DATA_WIDTH-1:0]                max_out,
  output logic [IDX_W-1:0]                     max_idx,
  output logic                                 busy
);

  // Reject parameter combinations that have no meaning at elaboration time.
  if (VEC_SIZE < 1 || FIXED_PNT < 0 || FIXED_PNT >= DATA_WIDTH) begin : gBadParams
    $error("vec_max_normalize: illegal VEC_SIZE/FIXED_PNT/DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SUB,
    DONE,
    HOLD
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                                state_q, state_d;
  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]   elem_q, elem_d;
  logic [DATA_WIDTH-1:0]                 runMax_q, runMax_d;
  logic [IDX_W-1:0]                      runIdx_q, runIdx_d;
  logic [IDX_W-1:0]                      scanIdx_q, scanIdx_d;
  logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]   vecOut_q, vecOut_d;
  logic [DATA_WIDTH-1:0]                 maxOut_q, maxOut_d;
  logic [IDX_W-1:0]                      maxIdx_q, maxIdx_d;
  logic                                  valid_q, valid_d;
  logic [DATA_WIDTH:0]                   diff;

  // State and datapath registers. Reset clears everything, including the
  // captured vector, so no stale data survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      elem_q    <= '0;
      runMax_q  <= '0;
      runIdx_q  <= '0;
      scanIdx_q <= '0;
      vecOut_q  <= '0;
      maxOut_q  <= '0;
      maxIdx_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      runMax_q  <= runMax_d;
      runIdx_q  <= runIdx_d;
      scanIdx_q <= scanIdx_d;
      vecOut_q  <= vecOut_d;
      maxOut_q  <= maxOut_d;
      maxIdx_q  <= maxIdx_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state and datapath logic. Every register holds by default. The
  // outputs change only on a completed SUB edge, so an abort leaves the
  // previous results visible.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    runMax_d  = runMax_q;
    runIdx_d  = runIdx_q;
    scanIdx_d = scanIdx_q;
    vecOut_d  = vecOut_q;
    maxOut_d  = maxOut_q;
    maxIdx_d  = maxIdx_q;
    valid_d   = 1'b0;
    diff      = '0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          elem_d    = vec_in;
          runMax_d  = vec_in[0];
          runIdx_d  = '0;
          scanIdx_d = IDX_W'(1);
          state_d   = (VEC_SIZE == 1) ? SUB : SCAN;
        end
      end

      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          // A strict greater-than keeps the earliest index when values tie.
          if ($signed(elem_q[scanIdx_q]) > $signed(runMax_q)) begin
            runMax_d = elem_q[scanIdx_q];
            runIdx_d = scanIdx_q;
          end
          scanIdx_d = scanIdx_q + 1'b1;
          if (scanIdx_q == IDX_W'(VEC_SIZE - 1)) begin
            state_d = SUB;
          end
        end
      end

      SUB: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < VEC_SIZE; i++) begin
            // Use one extra bit so the difference cannot wrap. The maximum
            // is never below any element, so only negative overflow can
            // happen. Overflow shows as the top two bits differing.
            diff = {elem_q[i][DATA_WIDTH-1], elem_q[i]} -
                   {runMax_q[DATA_WIDTH-1], runMax_q};
            if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
              vecOut_d[i] = SAT_MIN;
            end else begin
              vecOut_d[i] = diff[DATA_WIDTH-1:0];
            end
          end
          maxOut_d = runMax_q;
          maxIdx_d = runIdx_q;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = HOLD;
      end

      // Wait for the requester to drop enable. One request then produces
      // exactly one result pulse.
      HOLD: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q == SCAN) || (state_q == SUB);
  assign data_valid = valid_q;
  assign vec_out    = vecOut_q;
  assign max_out    = maxOut_q;
  assign max_idx    = maxIdx_q;

endmodule
